// File: rtl/pc_write_control_if.sv
// Bus bundle between the control FSM/ALU side and the program-counter unit.
interface pc_write_control_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 PCWrite;
    logic                 PCWriteCond;
    logic [2:0]           BranchType;
    logic                 Zero;
    logic                 Negative;
    logic [1:0]           PCSource;
    logic [WIDTH-1:0]     AluResult;
    logic [WIDTH-1:0]     AluOut;
    logic [WIDTH-1:0]     RegTarget;
    logic [25:0]          JumpIndex;
    logic                 Stall;
    logic                 Exception;
    logic [WIDTH-1:0]     PC;
    logic [WIDTH-1:0]     EPC;
    logic                 selPC;
    logic                 AddrErr;
    logic [CNT_WIDTH-1:0] BranchCount;
    logic [CNT_WIDTH-1:0] TakenCount;

    modport master (
        output PCWrite, PCWriteCond, BranchType, Zero, Negative, PCSource,
               AluResult, AluOut, RegTarget, JumpIndex, Stall, Exception,
        input  PC, EPC, selPC, AddrErr, BranchCount, TakenCount
    );

    modport slave (
        input  PCWrite, PCWriteCond, BranchType, Zero, Negative, PCSource,
               AluResult, AluOut, RegTarget, JumpIndex, Stall, Exception,
        output PC, EPC, selPC, AddrErr, BranchCount, TakenCount
    );
endinterface

// File: rtl/pc_write_control.sv
// Multicycle MIPS PC unit: branch decode, next-PC mux, stall, exception/EPC redirect.
// Optional saturating branch counters enabled by defining PC_PERF_COUNTERS_EN.
module pc_write_control #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
    parameter int unsigned      CNT_WIDTH    = 32
) (
    input logic               clk,
    input logic               reset,
    pc_write_control_if.slave bus
);
    typedef enum logic {RUN, FLUSH} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] epc_q;
    logic             addr_err_q;

    logic             cond_c;
    logic             req_c;
    logic             aligned_c;
    logic             sel_pc_c;
    logic             trap_c;
    logic [WIDTH-1:0] next_pc_c;

    // Branch decode, next-PC select and write qualification
    always_comb begin
        cond_c    = 1'b0;
        next_pc_c = bus.AluResult;
        case (bus.BranchType)
            3'b000:  cond_c = bus.Zero;
            3'b001:  cond_c = !bus.Zero;
            3'b010:  cond_c = bus.Zero | bus.Negative;
            3'b011:  cond_c = !bus.Zero & !bus.Negative;
            3'b100:  cond_c = bus.Negative;
            3'b101:  cond_c = !bus.Negative;
            default: cond_c = 1'b0;
        endcase
        case (bus.PCSource)
            2'b00:   next_pc_c = bus.AluResult;
            2'b01:   next_pc_c = bus.AluOut;
            2'b10:   next_pc_c = {pc_q[WIDTH-1:28], bus.JumpIndex, 2'b00};
            default: next_pc_c = bus.RegTarget;
        endcase
        aligned_c = (next_pc_c[1:0] == 2'b00);
        req_c     = (bus.PCWriteCond & cond_c) | bus.PCWrite;
        sel_pc_c  = (state_q == RUN) & req_c & !bus.Stall & !bus.Exception & aligned_c;
        trap_c    = (state_q == RUN) & req_c & !bus.Stall & !bus.Exception & !aligned_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            addr_err_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    addr_err_q <= 1'b0;
                    if (bus.Exception || trap_c) begin
                        pc_q       <= EXC_VECTOR;
                        epc_q      <= pc_q;
                        addr_err_q <= trap_c;
                        state_q    <= FLUSH;
                    end else if (sel_pc_c) begin
                        pc_q <= next_pc_c;
                    end
                end
                default: begin
                    // One dead cycle after a redirect; nothing is sampled here
                    addr_err_q <= 1'b0;
                    state_q    <= RUN;
                end
            endcase
        end
    end

`ifdef PC_PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] branch_cnt_q;
    logic [CNT_WIDTH-1:0] taken_cnt_q;
    logic                 branch_ev_c;

    assign branch_ev_c = (state_q == RUN) & bus.PCWriteCond & !bus.Stall & !bus.Exception;

    // Saturating counters: stick at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else if (branch_ev_c) begin
            if (branch_cnt_q != '1)
                branch_cnt_q <= branch_cnt_q + CNT_WIDTH'(1);
            if (cond_c && aligned_c && taken_cnt_q != '1)
                taken_cnt_q <= taken_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.BranchCount = branch_cnt_q;
    assign bus.TakenCount  = taken_cnt_q;
`else
    assign bus.BranchCount = '0;
    assign bus.TakenCount  = '0;
`endif

    assign bus.PC      = pc_q;
    assign bus.EPC     = epc_q;
    assign bus.AddrErr = addr_err_q;
    assign bus.selPC   = sel_pc_c;
endmodule
